// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t  : responder FSM states
//   LANES    : number of byte lanes per word
//   LANE_W   : width of one lane in bits
//   word_idx : byte address -> word index
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Drops the byte-within-word bits; callers truncate to their index width.
    function automatic int word_idx(input int addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Core data-port bus between the initiator (master) and the responder (slave).
//   req   : request, held with addr/we/wdata until ack
//   addr  : byte address (ADDR_W bits)
//   we    : byte-lane write strobes, 0 = read
//   wdata : write data
//   rdata : read data, meaningful while ack=1
//   ack   : one-cycle completion pulse
//   err   : access error, meaningful while ack=1
interface dmem_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              err;

    modport master (
        output req, addr, we, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  req, addr, we, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/dmem_lane.sv
// One 8-bit storage lane of the data memory.
//   clk   : clock
//   nrst  : synchronous active-low reset; clears the read register, blocks writes
//   wr_en : write mem[idx] with wdata on this edge
//   rd_en : capture mem[idx] (pre-write value) into rdata on this edge
//   clr   : when capturing, load 0 instead of the stored byte
//   idx   : word index
//   wdata : write byte
//   rdata : registered read byte
// Storage itself is never cleared by reset.
module dmem_lane #(
    parameter int IW     = 6,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr,
    input  logic [IW-1:0]     idx,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [2**IW];

    always_ff @(posedge clk) begin
        if (nrst && wr_en) begin
            mem[idx] <= wdata;
        end
    end

    // Same-edge read sees the old contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= clr ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: memory end of the core's byte-lane load/store port.
// Serves one req/ack transaction at a time, inserting WAIT_STATES wait cycles
// after accept, then a one-cycle ack. Reads return the word as it was before
// any write in the same transaction.
//   clk  : clock, rising edge
//   nrst : synchronous active-low reset
//   bus  : dmem_if slave modport (req/addr/we/wdata in, rdata/ack/err out)
// Parameters: ADDR_W (byte address width), WAIT_STATES (0..15).
// Optional feature macro DMEM_ALIGN_CHK_EN: flags accesses with addr[1:0]!=0
// with err=1, rdata=0 and no write. Without it err is constant 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input logic   clk,
    input logic   nrst,
    dmem_if.slave bus
);

    localparam int IW = ADDR_W - 2;
    localparam int CW = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          we_q;
    logic [31:0]         wdata_q;

    logic [ADDR_W-1:0]   eff_addr;
    logic [3:0]          eff_we;
    logic [31:0]         eff_wdata;
    logic [IW-1:0]       eff_idx;
    logic                enter_resp;
    logic                mis;
    logic [31:0]         lane_rdata;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                we_q    <= bus.we;
                wdata_q <= bus.wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    cnt_nxt   = CW'(WAIT_STATES);
                    state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so the
    // request fields come straight off the bus rather than from the latches.
    assign eff_addr   = (state == IDLE) ? bus.addr  : addr_q;
    assign eff_we     = (state == IDLE) ? bus.we    : we_q;
    assign eff_wdata  = (state == IDLE) ? bus.wdata : wdata_q;
    assign eff_idx    = IW'(word_idx(int'(eff_addr)));
    assign enter_resp = (state_nxt == RESP);

`ifdef DMEM_ALIGN_CHK_EN
    logic err_q;

    assign mis = (eff_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= mis;
        end
    end

    assign bus.err = err_q;
`else
    assign mis     = 1'b0;
    assign bus.err = 1'b0;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dmem_lane #(
            .IW     (IW),
            .LANE_W (LANE_W)
        ) u_lane (
            .clk   (clk),
            .nrst  (nrst),
            .wr_en (enter_resp & eff_we[i] & ~mis),
            .rd_en (enter_resp),
            .clr   (mis),
            .idx   (eff_idx),
            .wdata (eff_wdata[i*LANE_W +: LANE_W]),
            .rdata (lane_rdata[i*LANE_W +: LANE_W])
        );
    end

    assign bus.rdata = lane_rdata;
    assign bus.ack   = (state == RESP);

endmodule
